// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - shared state encodings and widths for the hazard controller
package pipe_hazard_ctrl_pkg;

  localparam int HZ_CNT_W = 32;
  localparam int HZ_REG_W = 5;

  typedef enum logic [1:0] {
    HZ_ST_RUN   = 2'd0,
    HZ_ST_FLUSH = 2'd1,
    HZ_ST_DIV   = 2'd2
  } hz_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - pipeline-status inputs and stall/flush outputs of the hazard controller
interface pipe_hazard_ctrl_if
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = HZ_CNT_W
);

  logic                ds_valid;
  logic [HZ_REG_W-1:0] ds_rs1;
  logic [HZ_REG_W-1:0] ds_rs2;
  logic                ds_rs1_en;
  logic                ds_rs2_en;
  logic                es_valid;
  logic                es_gr_we;
  logic [HZ_REG_W-1:0] es_dest;
  logic                es_is_load;
  logic                es_br_taken;
  logic                es_div_start;
  logic                div_done;
  logic                ms_valid;
  logic                ms_is_load;
  logic                ms_data_ok;
  logic                halt_req;

  logic fs_stall, ds_stall, es_stall, ms_stall, ws_stall;
  logic fs_flush, ds_flush, es_flush, ms_flush, ws_flush;
  logic [CNT_W-1:0]    perf_stall_cyc;
  logic [CNT_W-1:0]    perf_flush_evt;
  logic                div_timeout;

  modport master (
    output ds_valid, ds_rs1, ds_rs2, ds_rs1_en, ds_rs2_en,
    output es_valid, es_gr_we, es_dest, es_is_load, es_br_taken, es_div_start, div_done,
    output ms_valid, ms_is_load, ms_data_ok, halt_req,
    input  fs_stall, ds_stall, es_stall, ms_stall, ws_stall,
    input  fs_flush, ds_flush, es_flush, ms_flush, ws_flush,
    input  perf_stall_cyc, perf_flush_evt, div_timeout
  );

  modport slave (
    input  ds_valid, ds_rs1, ds_rs2, ds_rs1_en, ds_rs2_en,
    input  es_valid, es_gr_we, es_dest, es_is_load, es_br_taken, es_div_start, div_done,
    input  ms_valid, ms_is_load, ms_data_ok, halt_req,
    output fs_stall, ds_stall, es_stall, ms_stall, ws_stall,
    output fs_flush, ds_flush, es_flush, ms_flush, ws_flush,
    output perf_stall_cyc, perf_flush_evt, div_timeout
  );

endinterface

// File: rtl/pipe_hazard_ctrl_raw_cmp.sv
// rtl/pipe_hazard_ctrl_raw_cmp.sv - one ID source register against the EX destination
module hz_raw_cmp
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic                en_i,
  input  logic [HZ_REG_W-1:0] src_i,
  input  logic [HZ_REG_W-1:0] dest_i,
  input  logic                dest_we_i,
  input  logic                dest_nz_i,
  output logic                match_o
);

  assign match_o = en_i & dest_we_i & dest_nz_i & (src_i == dest_i);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush scheduler for the 5-stage pipeline with perf counters
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int FLUSH_EXTRA = 1,
  parameter int DIV_MAX     = 40,
  parameter int CNT_W       = HZ_CNT_W
) (
  input  logic             clk,
  input  logic             resetn,
  pipe_hazard_ctrl_if.slave hz
);

  localparam int FW = (FLUSH_EXTRA > 0) ? $clog2(FLUSH_EXTRA + 1) : 1;
  localparam int DW = (DIV_MAX > 0) ? $clog2(DIV_MAX + 1) : 1;

  hz_state_e        state_q, state_d;
  logic [FW-1:0]    fcnt_q, fcnt_d;
  logic [DW-1:0]    dcnt_q, dcnt_d;
  logic             tmo_q, tmo_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic dest_nz, rs1_hit, rs2_hit;
  logic load_use, mem_wait, div_wait, br_fire;
  logic fs_stall_c, ds_stall_c, es_stall_c, ms_stall_c;
  logic fs_flush_c, ds_flush_c;

  assign dest_nz = (hz.es_dest != '0);

  hz_raw_cmp u_cmp_rs1 (
    .en_i(hz.ds_rs1_en), .src_i(hz.ds_rs1), .dest_i(hz.es_dest),
    .dest_we_i(hz.es_gr_we), .dest_nz_i(dest_nz), .match_o(rs1_hit)
  );

  hz_raw_cmp u_cmp_rs2 (
    .en_i(hz.ds_rs2_en), .src_i(hz.ds_rs2), .dest_i(hz.es_dest),
    .dest_we_i(hz.es_gr_we), .dest_nz_i(dest_nz), .match_o(rs2_hit)
  );

  assign load_use = hz.ds_valid & hz.es_valid & hz.es_is_load & (rs1_hit | rs2_hit);
  assign mem_wait = hz.ms_valid & hz.ms_is_load & ~hz.ms_data_ok;
  assign div_wait = (state_q == HZ_ST_DIV) & ~hz.div_done;

  assign es_stall_c = mem_wait | div_wait | hz.halt_req;
  assign ms_stall_c = mem_wait | hz.halt_req;
  assign br_fire    = hz.es_valid & hz.es_br_taken & ~es_stall_c;

  // A flushed stage must not also hold, otherwise the killed instruction would linger.
  assign fs_flush_c = br_fire | (state_q == HZ_ST_FLUSH);
  assign ds_flush_c = br_fire;
  assign fs_stall_c = (load_use | es_stall_c) & ~fs_flush_c;
  assign ds_stall_c = (load_use | es_stall_c) & ~ds_flush_c;

  assign hz.fs_stall = resetn & fs_stall_c;
  assign hz.ds_stall = resetn & ds_stall_c;
  assign hz.es_stall = resetn & es_stall_c;
  assign hz.ms_stall = resetn & ms_stall_c;
  assign hz.ws_stall = resetn & hz.halt_req;
  assign hz.fs_flush = resetn & fs_flush_c;
  assign hz.ds_flush = resetn & ds_flush_c;
  assign hz.es_flush = 1'b0;
  assign hz.ms_flush = 1'b0;
  assign hz.ws_flush = 1'b0;

  assign hz.perf_stall_cyc = stall_cnt_q;
  assign hz.perf_flush_evt = flush_cnt_q;
  assign hz.div_timeout    = tmo_q;

  always_comb begin
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    dcnt_d      = dcnt_q;
    tmo_d       = tmo_q;
    stall_cnt_d = stall_cnt_q + CNT_W'(ds_stall_c);
    flush_cnt_d = flush_cnt_q + CNT_W'(br_fire);
    if (!hz.halt_req) begin
      unique case (state_q)
        HZ_ST_RUN: begin
          if (hz.es_div_start && hz.es_valid) begin
            state_d = HZ_ST_DIV;
            dcnt_d  = '0;
          end else if (br_fire && (FLUSH_EXTRA > 0)) begin
            state_d = HZ_ST_FLUSH;
            fcnt_d  = FW'(FLUSH_EXTRA);
          end
        end
        HZ_ST_FLUSH: begin
          if (br_fire) begin
            fcnt_d = FW'(FLUSH_EXTRA);
          end else if (fcnt_q == FW'(1)) begin
            state_d = HZ_ST_RUN;
          end else begin
            fcnt_d = fcnt_q - FW'(1);
          end
        end
        HZ_ST_DIV: begin
          if (hz.div_done) begin
            state_d = HZ_ST_RUN;
            dcnt_d  = '0;
          end else if (dcnt_q == DW'(DIV_MAX)) begin
            tmo_d = 1'b1;
          end else begin
            dcnt_d = dcnt_q + DW'(1);
          end
        end
        default: state_d = HZ_ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= HZ_ST_RUN;
      fcnt_q      <= '0;
      dcnt_q      <= '0;
      tmo_q       <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      dcnt_q      <= dcnt_d;
      tmo_q       <= tmo_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed self-checking bench for pipe_hazard_ctrl (DIV_MAX=5, FLUSH_EXTRA=1)
module tb_pipe_hazard_ctrl;

  logic clk;
  logic resetn;
  int   n_chk;
  int   n_fail;

  pipe_hazard_ctrl_if hz ();

  pipe_hazard_ctrl #(.FLUSH_EXTRA(1), .DIV_MAX(5), .CNT_W(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .hz     (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [4:0] stl = {hz.fs_stall, hz.ds_stall, hz.es_stall, hz.ms_stall, hz.ws_stall};
  wire [4:0] fl  = {hz.fs_flush, hz.ds_flush, hz.es_flush, hz.ms_flush, hz.ws_flush};

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic idle();
    hz.ds_valid = 0; hz.ds_rs1 = 0; hz.ds_rs2 = 0; hz.ds_rs1_en = 0; hz.ds_rs2_en = 0;
    hz.es_valid = 0; hz.es_gr_we = 0; hz.es_dest = 0; hz.es_is_load = 0;
    hz.es_br_taken = 0; hz.es_div_start = 0; hz.div_done = 0;
    hz.ms_valid = 0; hz.ms_is_load = 0; hz.ms_data_ok = 0; hz.halt_req = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic div_run(input int n_stall);
    idle();
    hz.es_valid = 1; hz.es_div_start = 1;
    #2 chk("div_issue", 32'(stl), 32'h0);
    tick();
    hz.es_div_start = 0;
    for (int i = 0; i < n_stall; i++) begin
      #2 chk("div_wait", 32'(stl), 32'b11100);
      tick();
    end
    hz.div_done = 1;
    #2 chk("div_done", 32'(stl), 32'h0);
    tick();
    idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0;
    n_fail = 0;
    resetn = 0;
    idle();
    hz.halt_req = 1;
    tick();
    #2 chk("rst_stall", 32'(stl), 32'h0);
    chk("rst_flush", 32'(fl), 32'h0);
    chk("rst_pstall", hz.perf_stall_cyc, 0);
    chk("rst_pflush", hz.perf_flush_evt, 0);
    chk("rst_tmo", 32'(hz.div_timeout), 0);
    idle();
    tick();
    tick();
    resetn = 1;

    // load-use
    hz.ds_valid = 1; hz.ds_rs1 = 0; hz.ds_rs1_en = 1;
    hz.es_valid = 1; hz.es_is_load = 1; hz.es_gr_we = 1; hz.es_dest = 0;
    #2 chk("lu_r0", 32'(stl), 32'h0);
    hz.es_dest = 4; hz.ds_rs1 = 4; hz.ds_rs1_en = 0; hz.ds_rs2 = 1; hz.ds_rs2_en = 1;
    #2 chk("lu_en0", 32'(stl), 32'h0);
    hz.ds_rs1_en = 1;
    #2 chk("lu", 32'(stl), 32'b11000);
    tick();
    idle();
    hz.ms_valid = 1; hz.ms_is_load = 1; hz.ms_data_ok = 1;
    #2 chk("lu_rel", 32'(stl), 32'h0);
    chk("lu_pstall", hz.perf_stall_cyc, 1);

    // load data wait
    hz.ms_data_ok = 0;
    for (int i = 0; i < 3; i++) begin
      #2 chk("mem_wait", 32'(stl), 32'b11110);
      tick();
    end
    hz.ms_data_ok = 1;
    #2 chk("mem_rel", 32'(stl), 32'h0);
    chk("mem_pstall", hz.perf_stall_cyc, 4);
    tick();

    // taken branch
    idle();
    hz.es_valid = 1; hz.es_br_taken = 1;
    #2 chk("br_t0", 32'(fl), 32'b11000);
    chk("br_t0_stall", 32'(stl), 32'h0);
    tick();
    idle();
    #2 chk("br_t1", 32'(fl), 32'b10000);
    chk("br_pflush", hz.perf_flush_evt, 1);
    tick();
    #2 chk("br_t2", 32'(fl), 32'h0);

    // divide: 5 wait cycles stays below timeout, 10 exceeds it
    div_run(5);
    #2 chk("div5_tmo", 32'(hz.div_timeout), 0);
    chk("div5_pstall", hz.perf_stall_cyc, 9);
    div_run(10);
    #2 chk("div10_tmo", 32'(hz.div_timeout), 1);
    chk("div10_pstall", hz.perf_stall_cyc, 19);
    tick();
    tick();
    #2 chk("tmo_sticky", 32'(hz.div_timeout), 1);

    // halt
    hz.halt_req = 1;
    #2 chk("halt", 32'(stl), 32'b11111);
    tick();
    hz.halt_req = 0;
    #2 chk("halt_pstall", hz.perf_stall_cyc, 20);

    // branch blocked by mem_wait
    hz.ms_valid = 1; hz.ms_is_load = 1; hz.ms_data_ok = 0;
    hz.es_valid = 1; hz.es_br_taken = 1;
    #2 chk("brmw_stall", 32'(stl), 32'b11110);
    chk("brmw_noflush", 32'(fl), 32'h0);
    tick();
    hz.ms_data_ok = 1;
    #2 chk("brmw_fire", 32'(fl), 32'b11000);
    chk("brmw_fire_stall", 32'(stl), 32'h0);
    tick();
    chk("brmw_pflush", hz.perf_flush_evt, 2);
    chk("brmw_pstall", hz.perf_stall_cyc, 21);
    idle();
    #2 chk("brmw_t1", 32'(fl), 32'b10000);
    tick();

    // load-use together with branch: flush wins
    hz.ds_valid = 1; hz.ds_rs1 = 7; hz.ds_rs1_en = 1;
    hz.es_valid = 1; hz.es_is_load = 1; hz.es_gr_we = 1; hz.es_dest = 7; hz.es_br_taken = 1;
    #2 chk("lubr_stall", 32'(stl), 32'h0);
    chk("lubr_flush", 32'(fl), 32'b11000);
    tick();
    idle();
    #2 chk("lubr_t1", 32'(fl), 32'b10000);
    chk("lubr_pflush", hz.perf_flush_evt, 3);
    chk("lubr_pstall", hz.perf_stall_cyc, 21);
    tick();

    // reset during DIV_WAIT
    hz.es_valid = 1; hz.es_div_start = 1;
    tick();
    hz.es_div_start = 0;
    #2 chk("rdiv_pre", 32'(stl), 32'b11100);
    resetn = 0;
    #1 chk("rdiv_stall", 32'(stl), 32'h0);
    chk("rdiv_pstall", hz.perf_stall_cyc, 0);
    chk("rdiv_tmo", 32'(hz.div_timeout), 0);
    tick();
    resetn = 1;
    #2 chk("rdiv_run", 32'(stl), 32'h0);

    // reset during FLUSH
    idle();
    hz.es_valid = 1; hz.es_br_taken = 1;
    #2;
    tick();
    idle();
    #2 chk("rfl_pre", 32'(fl), 32'b10000);
    resetn = 0;
    #1 chk("rfl_flush", 32'(fl), 32'h0);
    chk("rfl_pflush", hz.perf_flush_evt, 0);
    tick();
    resetn = 1;
    #2 chk("rfl_run", 32'(fl), 32'h0);
    tick();
    chk("rfl_pstall", hz.perf_stall_cyc, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
